// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions raw push-button pins for the pong user project. Every channel
//   has its own 2-flop synchroniser, a debounce counter and registered
//   press/release pulses. All channels are independent and share clk/rst_n.
//
//   Optional build macro: BTN_REPEAT_EN
//     Defined   : while a button stays held, btn_press also pulses
//                 REPEAT_DELAY cycles after the accepted press, then every
//                 REPEAT_PERIOD cycles until btn_level drops.
//     Undefined : no repeat logic; exactly one btn_press per accepted press.
//
//   Timing: a raw edge that is held steady reaches btn_level 2 + DEBOUNCE_CYCLES
//   cycles later. The press/release pulse is high in the same cycle that
//   btn_level changes, for one cycle.
//
//   Reset is synchronous and active-low. It clears the synchronisers, so a
//   button held through reset is re-qualified from scratch.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // The counter is compared against this terminal value. It is never
  // incremented past it, so it never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [CNT_W-1:0] cnt_q [N_BTN];

  logic [N_BTN-1:0] mismatch;
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] rpt_fire;

  // Two-flop synchroniser per channel for the asynchronous pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // A new level is accepted on the cycle the counter already holds
  // DEBOUNCE_CYCLES-1 while the synchronised input still disagrees
  always_comb begin
    mismatch = '0;
    accept   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      mismatch[i] = sync_q2[i] ^ btn_level[i];
      accept[i]   = mismatch[i] && (cnt_q[i] == CNT_LAST);
    end
  end

  // Per-channel debounce counter and accepted level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_level <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!mismatch[i]) begin
          // Agreement (or end of a glitch) discards any partial count
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          btn_level[i] <= sync_q2[i];
          cnt_q[i]     <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef BTN_REPEAT_EN
  // The repeat counter must hold the larger of the two repeat intervals
  localparam int RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_NEED = $clog2(RPT_MAX + 1);
  localparam int RPT_W    = (RPT_NEED > CNT_W) ? RPT_NEED : CNT_W;
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q [N_BTN];
  logic [N_BTN-1:0] rpt_first_q;

  // A repeat fires while held. It is suppressed on the cycle that a release
  // is accepted, because btn_press and btn_release must never coincide.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_fire[i] = btn_level[i] && !accept[i] &&
                    (rpt_q[i] == (rpt_first_q[i] ? DLY_LAST : PER_LAST));
    end
  end

  // Repeat counter. It restarts on every pulse and is held clear while the
  // button is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_first_q <= '1;
      for (int i = 0; i < N_BTN; i++) begin
        rpt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!btn_level[i]) begin
          rpt_q[i]       <= '0;
          rpt_first_q[i] <= 1'b1;
        end else if (rpt_fire[i]) begin
          rpt_q[i]       <= '0;
          rpt_first_q[i] <= 1'b0;
        end else begin
          rpt_q[i] <= rpt_q[i] + RPT_W'(1);
        end
      end
    end
  end
`else
  // Repeats are disabled, so only accepted presses produce btn_press
  always_comb begin
    rpt_fire = '0;
  end
`endif

  // Registered event pulses, aligned with the btn_level update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= (accept & sync_q2) | rpt_fire;
      btn_release <= accept & ~sync_q2;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES=8,
//   REPEAT_DELAY=20 and REPEAT_PERIOD=6. A second instance with
//   DEBOUNCE_CYCLES=1 covers the minimum-latency corner.
//   Time base: inputs change at a negedge. The outputs are sampled at each
//   later negedge ("tick"). A held raw edge therefore shows on btn_level at
//   tick 10, or at tick 3 for the DEBOUNCE_CYCLES=1 instance.
module tb_button_conditioner;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 6;

`ifdef BTN_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic [N-1:0] raw1 = '0;
  logic [N-1:0] level1, press1, release1;

  int tests_run = 0;
  int tests_failed = 0;

  // clock / reset block
  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(8),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(1), .CNT_W(4),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw1),
    .btn_level(level1), .btn_press(press1), .btn_release(release1)
  );

  // scoreboard check: one comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] l,
                            input logic [N-1:0] p, input logic [N-1:0] r);
    check({tag, ".level"},   32'(btn_level),   32'(l));
    check({tag, ".press"},   32'(btn_press),   32'(p));
    check({tag, ".release"}, 32'(btn_release), 32'(r));
  endtask

  task automatic check_outs1(input string tag, input logic [N-1:0] l,
                             input logic [N-1:0] p, input logic [N-1:0] r);
    check({tag, ".level"},   32'(level1),   32'(l));
    check({tag, ".press"},   32'(press1),   32'(p));
    check({tag, ".release"}, 32'(release1), 32'(r));
  endtask

  initial begin : stim
    logic [N-1:0] el, ep, er;

    // Reset, then idle
    rst_n = 1'b0;
    btn_raw = '0;
    raw1 = '0;
    repeat (3) tick();
    check_outs("reset", 4'h0, 4'h0, 4'h0);
    check_outs1("reset1", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_outs("idle", 4'h0, 4'h0, 4'h0);
    end

    // ch0 press held for 60 ticks, then released. With repeats enabled the
    // pulses fall at 10, 30, 36, ... 66 while the level is high (10..69).
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      el = (k >= 10 && k < 70) ? 4'h1 : 4'h0;
      ep = (k == 10) ? 4'h1 : 4'h0;
      if (REPEAT_ON && k >= 30 && k < 70 && ((k - 30) % RP) == 0) ep = 4'h1;
      er = (k == 70) ? 4'h1 : 4'h0;
      check_outs("ch0_hold", el, ep, er);
      if (k == 60) btn_raw[0] = 1'b0;
    end

    // ch1 glitches: 5 high, 1 low, 17 times; never accepted
    for (int g = 0; g < 17; g++) begin
      btn_raw[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick();
        check_outs("ch1_glitch_hi", 4'h0, 4'h0, 4'h0);
      end
      btn_raw[1] = 1'b0;
      tick();
      check_outs("ch1_glitch_lo", 4'h0, 4'h0, 4'h0);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_outs("ch1_after", 4'h0, 4'h0, 4'h0);
    end

    // ch2 press, hold 15 ticks, then release for 30 ticks
    btn_raw[2] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_outs("ch2_press", (k >= 10) ? 4'h4 : 4'h0, (k == 10) ? 4'h4 : 4'h0, 4'h0);
    end
    btn_raw[2] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check_outs("ch2_release", (k < 10) ? 4'h4 : 4'h0, 4'h0, (k == 10) ? 4'h4 : 4'h0);
    end

    // ch3 held through a 1-cycle reset at tick 5; re-qualified afterwards
    btn_raw[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_outs("ch3_pre_rst", 4'h0, 4'h0, 4'h0);
    end
    rst_n = 1'b0;
    tick();
    check_outs("ch3_in_rst", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check_outs("ch3_post_rst", (k >= 10) ? 4'h8 : 4'h0, (k == 10) ? 4'h8 : 4'h0, 4'h0);
    end
    btn_raw[3] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_outs("ch3_release", (k < 10) ? 4'h8 : 4'h0, 4'h0, (k == 10) ? 4'h8 : 4'h0);
    end

    // Simultaneous press and release on ch0 and ch1
    btn_raw = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_outs("dual_press", (k >= 10) ? 4'h3 : 4'h0, (k == 10) ? 4'h3 : 4'h0, 4'h0);
    end
    btn_raw = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_outs("dual_release", (k < 10) ? 4'h3 : 4'h0, 4'h0, (k == 10) ? 4'h3 : 4'h0);
    end

    // DEBOUNCE_CYCLES=1 instance: total latency of 3 cycles
    raw1[2] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_outs1("d1_press", (k >= 3) ? 4'h4 : 4'h0, (k == 3) ? 4'h4 : 4'h0, 4'h0);
    end
    raw1[2] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_outs1("d1_release", (k < 3) ? 4'h4 : 4'h0, 4'h0, (k == 3) ? 4'h4 : 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
